// File: rtl/data_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
// Region select travels down the read pipeline alongside the captured data.
package data_mem_pkg;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  localparam logic [3:0]  OFF_TOHOST       = 4'h0;
  localparam logic [3:0]  OFF_CYCLE        = 4'h4;
  localparam logic [3:0]  OFF_SCRATCH      = 4'h8;
  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h8000_0000;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word RAM built from four 8-bit lanes with per-lane write enables; 1-cycle registered read-first output.
// Always ready, no backpressure; contents are never reset.
module byte_lane_ram #(
  parameter int ADDR_W    = 12,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [3:0][7:0] r_mem [DEPTH];
  logic [31:0]     r_rdata;

  // Read samples the array before this edge's lane writes land (read-first).
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_we[l]) r_mem[i_addr][l] <= i_wdata[8*l +: 8];
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder: byte-lane RAM plus MMIO (TOHOST, CYCLE, SCRATCH); reads land 2 cycles after address.
// Fully pipelined, one access per cycle, never stalls.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter              INIT_FILE = "",
  parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  data_mem_we_i,
  input  logic [31:0] data_mem_address_i,
  input  logic [31:0] data_mem_write_i,
  output logic [31:0] data_mem_read_o,
  output logic        test_done_o,
  output logic [31:0] test_result_o
);

  region_e     w_region;
  logic [3:0]  w_off;
  logic [3:0]  w_we;
  logic [3:0]  w_ram_we;
  logic [3:0]  w_mmio_we;
  logic [31:0] w_mmio_rd;
  logic [31:0] w_ram_rdata;
  logic        w_unused;

  region_e     r_region;
  logic [31:0] r_mmio_val;
  logic [31:0] r_read_dat;
  logic [31:0] r_cycle;
  logic [31:0] r_scratch;
  logic        r_test_done;
  logic [31:0] r_test_result;

  assign w_unused = ^data_mem_address_i[1:0];

  always_comb begin
    w_region = REG_NONE;
    if (data_mem_address_i[31:28] == 4'h0)
      w_region = REG_RAM;
    else if (data_mem_address_i[31:4] == MMIO_BASE[31:4])
      w_region = REG_MMIO;
  end

  assign w_off     = {data_mem_address_i[3:2], 2'b00};
  // A write presented while reset is high must not land anywhere.
  assign w_we      = reset ? 4'b0000 : data_mem_we_i;
  assign w_ram_we  = (w_region == REG_RAM)  ? w_we : 4'b0000;
  assign w_mmio_we = (w_region == REG_MMIO) ? w_we : 4'b0000;

  always_comb begin
    w_mmio_rd = 32'h0;
    case (w_off)
      OFF_TOHOST:  w_mmio_rd = r_test_result;
      OFF_CYCLE:   w_mmio_rd = r_cycle;
      OFF_SCRATCH: w_mmio_rd = r_scratch;
      default:     w_mmio_rd = 32'h0;
    endcase
  end

  byte_lane_ram #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_addr (data_mem_address_i[ADDR_W+1:2]),
    .i_wdata(data_mem_write_i),
    .o_rdata(w_ram_rdata)
  );

  // Stage 1 region is reset to NONE so the un-reset RAM output never leaks out after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_region      <= REG_NONE;
      r_mmio_val    <= 32'h0;
      r_read_dat    <= 32'h0;
      r_cycle       <= 32'h0;
      r_scratch     <= 32'h0;
      r_test_done   <= 1'b0;
      r_test_result <= 32'h0;
    end else begin
      r_cycle    <= r_cycle + 32'd1;
      r_region   <= w_region;
      r_mmio_val <= w_mmio_rd;
      case (r_region)
        REG_RAM:  r_read_dat <= w_ram_rdata;
        REG_MMIO: r_read_dat <= r_mmio_val;
        default:  r_read_dat <= 32'h0;
      endcase
      if (w_mmio_we != 4'b0000) begin
        if (w_off == OFF_TOHOST) begin
          r_test_done   <= 1'b1;
          r_test_result <= merge_bytes(r_test_result, data_mem_write_i, w_mmio_we);
        end
        if (w_off == OFF_SCRATCH)
          r_scratch <= merge_bytes(r_scratch, data_mem_write_i, w_mmio_we);
      end
    end
  end

  assign data_mem_read_o = r_read_dat;
  assign test_done_o     = r_test_done;
  assign test_result_o   = r_test_result;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: inputs driven and outputs sampled on the falling edge.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic [3:0]  data_mem_we_i;
  logic [31:0] data_mem_address_i;
  logic [31:0] data_mem_write_i;
  logic [31:0] data_mem_read_o;
  logic        test_done_o;
  logic [31:0] test_result_o;

  int n_cmp;
  int n_err;

  localparam logic [31:0] A_TOHOST  = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE   = 32'h8000_0004;
  localparam logic [31:0] A_SCRATCH = 32'h8000_0008;
  localparam logic [31:0] A_UNMAP   = 32'h8000_000C;
  localparam logic [31:0] A_IDLE    = 32'h4000_0000;

  data_mem_responder #(.ADDR_W(12)) dut (
    .clk               (clk),
    .reset             (reset),
    .data_mem_we_i     (data_mem_we_i),
    .data_mem_address_i(data_mem_address_i),
    .data_mem_write_i  (data_mem_write_i),
    .data_mem_read_o   (data_mem_read_o),
    .test_done_o       (test_done_o),
    .test_result_o     (test_result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for one cycle; returns at the falling edge after it was sampled.
  task automatic drive(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    data_mem_we_i      = we;
    data_mem_address_i = addr;
    data_mem_write_i   = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(4'b0000, A_IDLE, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] v);
    drive(4'b0000, addr, 32'h0);
    idle();
    v = data_mem_read_o;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    idle();
    idle();
    n_cmp++; if (data_mem_read_o !== 32'h0) begin n_err++; $display("FAIL reset_read: got %h want %h", data_mem_read_o, 32'h0); end
    n_cmp++; if (test_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", test_done_o); end
    n_cmp++; if (test_result_o !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", test_result_o); end
    reset = 1'b0;
    rd(A_CYCLE, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_cycle: got %h want 0", v); end
    rd(A_SCRATCH, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_scratch: got %h want 0", v); end
    rd(A_UNMAP, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL mmio_unmapped: got %h want 0", v); end
  endtask

  task automatic test_full_word();
    logic [31:0] v;
    drive(4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, v);
    n_cmp++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL full_word: got %h want DEADBEEF", v); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] v;
    drive(4'b0010, 32'h0000_0010, 32'h0000_AA00);
    rd(32'h0000_0010, v);
    n_cmp++; if (v !== 32'hDEAD_AAEF) begin n_err++; $display("FAIL merge_lane1: got %h want DEADAAEF", v); end
    drive(4'b1000, 32'h0000_0010, 32'h1100_0000);
    rd(32'h0000_0010, v);
    n_cmp++; if (v !== 32'h11AD_AAEF) begin n_err++; $display("FAIL merge_lane3: got %h want 11ADAAEF", v); end
  endtask

  task automatic test_read_first();
    logic [31:0] v;
    drive(4'hF, 32'h0000_0020, 32'h0000_0001);
    drive(4'hF, 32'h0000_0020, 32'h0000_0002);
    idle();
    n_cmp++; if (data_mem_read_o !== 32'h1) begin n_err++; $display("FAIL read_first: got %h want 00000001", data_mem_read_o); end
    rd(32'h0000_0020, v);
    n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL read_after_rf: got %h want 00000002", v); end
  endtask

  task automatic test_back_to_back();
    drive(4'hF, 32'h0000_0000, 32'h1111_1111);
    drive(4'hF, 32'h0000_0004, 32'h2222_2222);
    drive(4'hF, 32'h0000_0008, 32'h3333_3333);
    drive(4'b0000, 32'h0000_0000, 32'h0);
    drive(4'b0000, 32'h0000_0004, 32'h0);
    n_cmp++; if (data_mem_read_o !== 32'h1111_1111) begin n_err++; $display("FAIL pipe_0: got %h want 11111111", data_mem_read_o); end
    drive(4'b0000, 32'h0000_0008, 32'h0);
    n_cmp++; if (data_mem_read_o !== 32'h2222_2222) begin n_err++; $display("FAIL pipe_4: got %h want 22222222", data_mem_read_o); end
    idle();
    n_cmp++; if (data_mem_read_o !== 32'h3333_3333) begin n_err++; $display("FAIL pipe_8: got %h want 33333333", data_mem_read_o); end
  endtask

  task automatic test_alias_unmapped();
    logic [31:0] v;
    drive(4'hF, 32'h0000_0000, 32'h0000_0005);
    rd(32'h0000_4000, v);
    n_cmp++; if (v !== 32'h5) begin n_err++; $display("FAIL alias: got %h want 00000005", v); end
    rd(32'h4000_0000, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h want 0", v); end
    drive(4'hF, 32'h4000_0000, 32'hFFFF_FFFF);
    rd(32'h0000_0000, v);
    n_cmp++; if (v !== 32'h5) begin n_err++; $display("FAIL unmapped_write: got %h want 00000005", v); end
  endtask

  task automatic test_mmio();
    logic [31:0] v;
    logic [31:0] c0;
    logic [31:0] c1;
    drive(4'hF, A_TOHOST, 32'h0000_0001);
    n_cmp++; if (test_done_o !== 1'b1) begin n_err++; $display("FAIL tohost_done: got %b want 1", test_done_o); end
    n_cmp++; if (test_result_o !== 32'h1) begin n_err++; $display("FAIL tohost_result: got %h want 00000001", test_result_o); end
    rd(A_TOHOST, v);
    n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL tohost_read: got %h want 00000001", v); end
    drive(4'b0100, A_TOHOST, 32'h0055_0000);
    n_cmp++; if (test_result_o !== 32'h0055_0001) begin n_err++; $display("FAIL tohost_merge: got %h want 00550001", test_result_o); end
    drive(4'hF, A_SCRATCH, 32'hCAFE_F00D);
    rd(A_SCRATCH, v);
    n_cmp++; if (v !== 32'hCAFE_F00D) begin n_err++; $display("FAIL scratch: got %h want CAFEF00D", v); end
    drive(4'b0001, A_SCRATCH, 32'h0000_0042);
    rd(A_SCRATCH, v);
    n_cmp++; if (v !== 32'hCAFE_F042) begin n_err++; $display("FAIL scratch_byte: got %h want CAFEF042", v); end
    rd(A_CYCLE, c0);
    repeat (8) idle();
    rd(A_CYCLE, c1);
    n_cmp++; if (c1 - c0 !== 32'd10) begin n_err++; $display("FAIL cycle_delta: got %0d want 10", c1 - c0); end
  endtask

  task automatic test_cycle_wrap();
    force dut.r_cycle = 32'hFFFF_FFFF;
    drive(4'b0000, A_CYCLE, 32'h0);
    release dut.r_cycle;
    drive(4'b0000, A_CYCLE, 32'h0);
    n_cmp++; if (data_mem_read_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cycle_max: got %h want FFFFFFFF", data_mem_read_o); end
    drive(4'b0000, A_CYCLE, 32'h0);
    idle();
    n_cmp++; if (data_mem_read_o !== 32'h0) begin n_err++; $display("FAIL cycle_wrap: got %h want 0", data_mem_read_o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    drive(4'b0000, 32'h0000_0010, 32'h0);
    reset = 1'b1;
    drive(4'hF, 32'h0000_0010, 32'h0000_0000);
    reset = 1'b0;
    n_cmp++; if (data_mem_read_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_read: got %h want 0", data_mem_read_o); end
    n_cmp++; if (test_done_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b want 0", test_done_o); end
    n_cmp++; if (test_result_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_result: got %h want 0", test_result_o); end
    drive(4'b0000, A_CYCLE, 32'h0);
    n_cmp++; if (data_mem_read_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_drop: got %h want 0", data_mem_read_o); end
    idle();
    n_cmp++; if (data_mem_read_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_cycle: got %h want 0", data_mem_read_o); end
    rd(32'h0000_0010, v);
    n_cmp++; if (v !== 32'h11AD_AAEF) begin n_err++; $display("FAIL rst_ram_kept: got %h want 11ADAAEF", v); end
    reset = 1'b1;
    drive(4'hF, A_TOHOST, 32'h0000_0007);
    reset = 1'b0;
    idle();
    n_cmp++; if (test_done_o !== 1'b0) begin n_err++; $display("FAIL rst_tohost_done: got %b want 0", test_done_o); end
    n_cmp++; if (test_result_o !== 32'h0) begin n_err++; $display("FAIL rst_tohost_result: got %h want 0", test_result_o); end
  endtask

  initial begin
    n_cmp              = 0;
    n_err              = 0;
    reset              = 1'b1;
    data_mem_we_i      = 4'b0000;
    data_mem_address_i = A_IDLE;
    data_mem_write_i   = 32'h0;
    @(negedge clk);
    test_reset();
    test_full_word();
    test_byte_merge();
    test_read_first();
    test_back_to_back();
    test_alias_unmapped();
    test_mmio();
    test_cycle_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
